zone_update_ctrl: RTL and testbench

- Sequences the per-frame transfer of the 360 zone brightness values from the block_360 result buffer into the MiniLED_driver shadow bank.
- Triggered by a frame-done pulse. Reads every zone and applies the led_mode override, plus optional global gain.
- Writes each value to the driver shadow bank, then issues a bank-swap pulse only inside the driver's safe (idle) window.
- Sits between block_360 and MiniLED_driver in the I_clk (50 MHz) domain.

---
 rtl/zone_update_ctrl.sv | 159 +++++++++++++++
 tb/tb_zone_update_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_update_ctrl.sv
// zone_update_ctrl: per-frame copy of zone brightness into the driver shadow bank, then a bank swap in the driver's idle window (optional gain: ZONE_UPD_GAIN_EN)
module zone_update_ctrl #(
    parameter int NZONES = 360,
    parameter int AW     = 9,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic          I_frame_done,
    input  logic [1:0]    I_led_mode,
    input  logic [7:0]    I_gain,
    input  logic          I_drv_idle,
    output logic          O_rd_en,
    output logic [AW-1:0] O_rd_addr,
    input  logic [DW-1:0] I_rd_data,
    output logic          O_wr_en,
    output logic [AW-1:0] O_wr_addr,
    output logic [DW-1:0] O_wr_data,
    output logic          O_swap,
    output logic          O_busy,
    output logic [7:0]    O_overrun_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_COPY, S_DRAIN, S_WAIT_SWAP, S_SWAP} state_t;
    state_t              r_state, w_next;
    logic                r_pending;
    logic [1:0]          r_mode;
    logic [AW-1:0]       r_rd_addr;
    logic [4:0]          r_col;
    logic                r_rowp;
    logic [RD_LAT-1:0]   r_vld;
    logic [RD_LAT-1:0]   r_chk;
    logic [AW-1:0]       r_tag [RD_LAT];
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [DW-1:0]       r_wr_data;
    logic [7:0]          r_overrun;
    logic                w_start, w_last_rd, w_last_wr;
    logic [DW-1:0]       w_comp, w_val;
    assign w_start       = (r_state == S_IDLE) && (I_frame_done || r_pending);
    assign w_last_rd     = r_rd_addr == AW'(NZONES - 1);
    assign w_last_wr     = r_wr_en && (r_wr_addr == AW'(NZONES - 1));
    assign O_rd_addr     = r_rd_addr;
    assign O_wr_en       = r_wr_en;
    assign O_wr_addr     = r_wr_addr;
    assign O_wr_data     = r_wr_data;
    assign O_overrun_cnt = r_overrun;
    // Next-state and state-decoded strobes
    always_comb begin
        w_next  = r_state;
        O_rd_en = 1'b0;
        O_busy  = 1'b1;
        O_swap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                O_busy = 1'b0;
                if (w_start) w_next = S_COPY;
            end
            S_COPY: begin
                O_rd_en = 1'b1;
                if (w_last_rd) w_next = S_DRAIN;
            end
            S_DRAIN: if (w_last_wr) w_next = S_WAIT_SWAP;
            S_WAIT_SWAP: if (I_drv_idle) w_next = S_SWAP;
            S_SWAP: begin
                O_swap = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    // State register, read address walk with row/column tracking, trigger bookkeeping
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_mode    <= 2'd0;
            r_rd_addr <= '0;
            r_col     <= 5'd0;
            r_rowp    <= 1'b0;
            r_overrun <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_mode    <= I_led_mode;
                r_rd_addr <= '0;
                r_col     <= 5'd0;
                r_rowp    <= 1'b0;
            end else if (r_state == S_COPY && !w_last_rd) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_col     <= (r_col == 5'd19) ? 5'd0 : r_col + 5'd1;
                r_rowp    <= (r_col == 5'd19) ? ~r_rowp : r_rowp;
            end
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (I_frame_done && O_busy) begin
                r_pending <= 1'b1;
                if (r_pending && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
            end
        end
    end
    // Address tag and checkerboard bit travel alongside the read latency
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_vld <= '0;
            r_chk <= '0;
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_vld[0] <= O_rd_en;
            r_chk[0] <= r_rd_addr[0] ^ r_rowp;
            r_tag[0] <= r_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_chk[i] <= r_chk[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end
`ifdef ZONE_UPD_GAIN_EN
    logic [7:0]    r_gain;
    logic [DW+8:0] w_prod;
    // Gain is frozen for the whole copy
    always_ff @(posedge I_clk) begin
        if (I_rst) r_gain <= 8'd0;
        else if (w_start) r_gain <= I_gain;
    end
    // Rounded scale by gain/256, clamped to full scale
    always_comb begin
        w_prod = (DW+9)'(I_rd_data) * (DW+9)'(r_gain) + (DW+9)'(128);
        w_comp = w_prod[DW+8] | w_prod[DW+7] ? '1 : w_prod[DW+7:8];
        w_comp = (w_prod[DW+8:8] > (DW+1)'({DW{1'b1}})) ? '1 : w_prod[DW+7:8];
    end
`else
    logic w_unused_gain;
    assign w_unused_gain = ^I_gain;
    assign w_comp        = I_rd_data;
`endif
    // Mode override of the returned read data
    always_comb begin
        w_val = (r_mode == 2'd0) ? w_comp :
                (r_mode == 2'd1) ? '1 :
                (r_mode == 2'd2) ? '0 :
                (r_chk[RD_LAT-1] ? '1 : '0);
    end
    // Single registered write stage; address holds between writes
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_vld[RD_LAT-1];
            if (r_vld[RD_LAT-1]) begin
                r_wr_addr <= r_tag[RD_LAT-1];
                r_wr_data <= w_val;
            end
        end
    end
endmodule

// File: tb/tb_zone_update_ctrl.sv
// tb_zone_update_ctrl: randomized directed checks of zone_update_ctrl against a zone-rule reference model
module tb_zone_update_ctrl;
    localparam int NZ = 360;
    logic       clk = 1'b0;
    logic       rst, frame_done, drv_idle;
    logic [1:0] led_mode;
    logic [7:0] gain;
    logic       rd_en, wr_en, swap, busy;
    logic [8:0] rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data, overrun;
    logic [7:0] mem [512];
    int checks = 0, failures = 0, cyc = 0;
    int wa[$], wd[$], wc[$], sc[$], rc[$], bf[$];
    logic prev_busy = 1'b0;

    always #10 clk = ~clk;

    zone_update_ctrl dut (
        .I_clk(clk), .I_rst(rst), .I_frame_done(frame_done), .I_led_mode(led_mode),
        .I_gain(gain), .I_drv_idle(drv_idle), .O_rd_en(rd_en), .O_rd_addr(rd_addr),
        .I_rd_data(rd_data), .O_wr_en(wr_en), .O_wr_addr(wr_addr), .O_wr_data(wr_data),
        .O_swap(swap), .O_busy(busy), .O_overrun_cnt(overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
        end
        if (swap === 1'b1) sc.push_back(cyc);
        if (rd_en === 1'b1 && rd_addr == 9'd0) rc.push_back(cyc);
        if (prev_busy && busy === 1'b0) bf.push_back(cyc);
        prev_busy <= (busy === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int model(input int mode, input int addr, input int data, input int g);
        int v;
        if (mode == 1) return 255;
        if (mode == 2) return 0;
        if (mode == 3) return ((addr % 2) != ((addr / 20) % 2)) ? 255 : 0;
        v = data;
`ifdef ZONE_UPD_GAIN_EN
        v = (data * g + 128) / 256;
        if (v > 255) v = 255;
`endif
        return v;
    endfunction

    task automatic check_xfer(input string tag, input int base, input int mode, input int g);
        int err = 0;
        for (int k = 0; k < NZ; k++)
            if (base + k >= wa.size() || wa[base+k] != k || wd[base+k] != model(mode, k, int'(mem[k]), g)) err++;
        chk(tag, err, 0);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NZ; k++) mem[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic trigger(output int t);
        t = cyc;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_rd_en"}, rd_en, 0);
        chk({pfx, "_wr_en"}, wr_en, 0);
        chk({pfx, "_swap"}, swap, 0);
        chk({pfx, "_overrun"}, overrun, 0);
        chk({pfx, "_rd_addr"}, rd_addr, 0);
        chk({pfx, "_wr_addr"}, wr_addr, 0);
        chk({pfx, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        int t, b, sb, bb, rb, s, c, g, m;
        for (int k = 0; k < 512; k++) mem[k] = 8'd0;
        rst = 1'b1; frame_done = 1'b0; drv_idle = 1'b1; led_mode = 2'd0; gain = 8'hFF;
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < NZ; k++) mem[k] = 8'(k);
        b = wa.size(); sb = sc.size(); bb = bf.size();
        trigger(t);
        wait_idle("t1_done", 600);
        chk("t1_wr_count", wa.size() - b, NZ);
        check_xfer("t1_data", b, 0, 255);
        chk("t1_first_wr_cyc", qget(wc, b), t + 3);
        chk("t1_swap_count", sc.size() - sb, 1);
        chk("t1_swap_cyc", qget(sc, sb), t + 364);
        chk("t1_busy_low_cyc", qget(bf, bb), t + 365);

        for (int mi = 1; mi <= 3; mi++) begin
            fill_rand();
            led_mode = 2'(mi);
            b = wa.size();
            trigger(t);
            led_mode = 2'($urandom_range(0, 3));
            wait_idle($sformatf("mode%0d_done", mi), 600);
            check_xfer($sformatf("mode%0d_data", mi), b, mi, 255);
            if (mi == 3) begin
                chk("cb_addr0", qget(wd, b), 8'h00);
                chk("cb_addr1", qget(wd, b + 1), 8'hFF);
                chk("cb_addr20", qget(wd, b + 20), 8'hFF);
                chk("cb_addr21", qget(wd, b + 21), 8'h00);
            end
        end

        fill_rand();
        g = $urandom_range(0, 255);
        gain = 8'(g); led_mode = 2'd0;
        b = wa.size();
        trigger(t);
        repeat (100) tick();
        led_mode = 2'd2; gain = 8'($urandom_range(0, 255));
        wait_idle("midmode_done", 600);
        check_xfer("midmode_data", b, 0, g);

        fill_rand();
        m = $urandom_range(0, 3);
        led_mode = 2'(m); drv_idle = 1'b0;
        b = wa.size(); sb = sc.size();
        trigger(t);
        repeat (NZ + 10) tick();
        repeat (500) tick();
        chk("hold_no_swap", sc.size() - sb, 0);
        chk("hold_busy", busy, 1);
        c = cyc;
        drv_idle = 1'b1;
        wait_idle("hold_done", 50);
        chk("hold_swap_cyc", qget(sc, sb), c + 1);
        check_xfer("hold_data", b, m, int'(gain));

        fill_rand();
        b = wa.size(); sb = sc.size(); rb = rc.size();
        trigger(t);
        for (int i = 0; i < 600 && swap !== 1'b1; i++) tick();
        s = cyc;
        chk("swaptrig_swap_cyc", s, t + 364);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        chk("swaptrig_restart_cyc", qget(rc, rb + 1), s + 2);
        wait_idle("swaptrig_done", 600);
        chk("swaptrig_overrun", overrun, 0);
        check_xfer("swaptrig_second", b + NZ, m, int'(gain));

        fill_rand();
        m = $urandom_range(0, 3);
        led_mode = 2'(m);
        b = wa.size(); sb = sc.size();
        trigger(t);
        repeat (50) tick();
        for (int i = 0; i < 3; i++) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            repeat (20) tick();
        end
        for (int i = 0; i < 1500 && sc.size() - sb < 2; i++) tick();
        repeat (400) tick();
        chk("merge_overrun", overrun, 2);
        chk("merge_wr_count", wa.size() - b, 2 * NZ);
        chk("merge_swaps", sc.size() - sb, 2);
        check_xfer("merge_first", b, m, int'(gain));
        check_xfer("merge_second", b + NZ, m, int'(gain));

        b = wa.size(); sb = sc.size();
        trigger(t);
        frame_done = 1'b1;
        repeat (300) tick();
        frame_done = 1'b0;
        for (int i = 0; i < 1500 && sc.size() - sb < 2; i++) tick();
        wait_idle("sat_done", 600);
        chk("sat_overrun", overrun, 255);
        chk("sat_swaps", sc.size() - sb, 2);

        fill_rand();
        b = wa.size(); sb = sc.size();
        trigger(t);
        for (int i = 0; i < 500 && wa.size() - b < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("midrst");
        repeat (400) tick();
        chk("midrst_no_swap", sc.size() - sb, 0);
        m = $urandom_range(0, 3);
        led_mode = 2'(m);
        b = wa.size();
        trigger(t);
        wait_idle("postrst_done", 600);
        chk("postrst_wr_count", wa.size() - b, NZ);
        check_xfer("postrst_data", b, m, int'(gain));

`ifdef ZONE_UPD_GAIN_EN
        fill_rand();
        mem[0] = 8'hFF; mem[1] = 8'h01;
        gain = 8'h80; led_mode = 2'd0;
        b = wa.size();
        trigger(t);
        wait_idle("gain80_done", 600);
        chk("gain80_ff", qget(wd, b), 8'h80);
        chk("gain80_01", qget(wd, b + 1), 8'h01);
        check_xfer("gain80_data", b, 0, 8'h80);
        fill_rand();
        gain = 8'h00;
        b = wa.size();
        trigger(t);
        wait_idle("gain0_done", 600);
        check_xfer("gain0_data", b, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
